// File: rtl/rx_majority_sampler.sv
// rx_majority_sampler: majority-vote oversampling bit sampler for the UART receive path
module rx_majority_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 7 || NUM_SAMPLES % 2 == 0) begin : g_bad_samples
    $error("NUM_SAMPLES must be odd and within 1..7");
  end
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t st, nxt;
  logic [PRESCALE_W-1:0] last, first, first_q, last_q;
  logic [CW-1:0] k, ones, ones_total;
  logic legal, start, abort, cap, done;
  always_comb begin
    last  = prescale >> 1;
    first = last - PRESCALE_W'(NUM_SAMPLES - 1);
    legal = !prescale[0] && prescale >= PRESCALE_W'(4) && last >= PRESCALE_W'(NUM_SAMPLES - 1);
  end
  always_ff @(posedge clk)
    if (!rst) st <= IDLE;
    else st <= nxt;
  // the window is judged against the latched FIRST/LAST so a prescale change mid-bit is ignored
  always_comb begin
    start = sample_en && legal && edge_cnt == first;
    abort = !sample_en || edge_cnt < first_q || edge_cnt > last_q;
    cap   = st == IDLE ? start : !abort && edge_cnt == first_q + PRESCALE_W'(k);
    done  = cap && (st == IDLE ? NUM_SAMPLES == 1 : k == CW'(NUM_SAMPLES - 1));
    nxt   = st == IDLE ? (start && !done ? COLLECT : IDLE) : (abort || done ? IDLE : COLLECT);
  end
  always_comb ones_total = (st == COLLECT ? ones : '0) + CW'(rx_in);
  always_ff @(posedge clk)
    if (!rst) begin
      k            <= '0;
      ones         <= '0;
      first_q      <= '0;
      last_q       <= '0;
      sampled_bit  <= 1'b0;
      sample_valid <= 1'b0;
      noise_err    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err      <= !legal;
      sample_valid <= done;
      if (done) begin
        sampled_bit <= ones_total > CW'(NUM_SAMPLES / 2);
        noise_err   <= ones_total != '0 && ones_total != CW'(NUM_SAMPLES);
      end
      if (st == IDLE && start) begin
        first_q <= first;
        last_q  <= last;
      end
      k    <= nxt == IDLE ? '0 : cap ? k + CW'(1) : k;
      ones <= nxt == IDLE ? '0 : cap ? ones_total : ones;
    end
endmodule
